noc_test_node: RTL and testbench

// - Traffic endpoint attached to one NoC router local port: generates a fixed burst of packets to a fixed destination and counts packets delivered to it.
// - Used in mesh simulation tops to prove end-to-end routing, e.g. (0,0)<->(1,1) on a 2x2 mesh.

---
 rtl/noc_pkg.sv | 60 ++++++
 rtl/noc_test_node_rx.sv | 130 +++++++++++++
 rtl/noc_test_node.sv | 190 +++++++++++++++++++
 tb/tb_noc_test_node.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the NoC test endpoint: default flit width, coordinate
// width, bit offsets of the header and payload fields, the TX state encoding
// and helpers that assemble the 24 meaningful low bits of a flit.
//
// Header  bits [23:0] = {seq[7:0], src_y[3:0], src_x[3:0], dst_y[3:0], dst_x[3:0]}
// Payload bits [23:0] = {src_y[3:0], src_x[3:0], seq[7:0], idx[7:0]}
// Bits above 23 are always zero.
// ---------------------------------------------------------------------------
package noc_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int COORD_W    = 4;
  localparam int SEQ_W      = 8;
  localparam int IDX_W      = 8;
  localparam int FIELDS_W   = 24;

  // Header field offsets
  localparam int HDR_DX_LSB  = 0;
  localparam int HDR_DY_LSB  = 4;
  localparam int HDR_SX_LSB  = 8;
  localparam int HDR_SY_LSB  = 12;
  localparam int HDR_SEQ_LSB = 16;

  // Payload field offsets
  localparam int PAY_IDX_LSB = 0;
  localparam int PAY_SEQ_LSB = 8;
  localparam int PAY_SX_LSB  = 16;
  localparam int PAY_SY_LSB  = 20;

  typedef enum logic [2:0] {
    TX_WAIT,
    TX_HEAD,
    TX_BODY,
    TX_TAIL,
    TX_GAP,
    TX_DONE
  } tx_state_t;

  function automatic logic [FIELDS_W-1:0] make_header(
    input logic [COORD_W-1:0] dx,
    input logic [COORD_W-1:0] dy,
    input logic [COORD_W-1:0] sx,
    input logic [COORD_W-1:0] sy,
    input logic [SEQ_W-1:0]   seq
  );
    return {seq, sy, sx, dy, dx};
  endfunction

  function automatic logic [FIELDS_W-1:0] make_payload(
    input logic [COORD_W-1:0] sx,
    input logic [COORD_W-1:0] sy,
    input logic [SEQ_W-1:0]   seq,
    input logic [IDX_W-1:0]   idx
  );
    return {sy, sx, seq, idx};
  endfunction

endpackage

// File: rtl/noc_test_node_rx.sv
// ---------------------------------------------------------------------------
// noc_test_node_rx
// Receive side of the NoC test endpoint. Always ready after reset, tracks
// packet framing with an in_pkt flag and counts complete packets (saturating
// at 255).
//
// Optional feature macro: NOC_TEST_NODE_CHECK_EN
//   When defined, checks the destination of each accepted header and the
//   idx/seq fields of each in-packet non-header flit; mismatches increment
//   check_err_num and the packet is excluded from receive_num.
//
// Ports
//   clk               in   clock
//   srst              in   synchronous active-high reset
//   receive_valid     in   inbound flit valid
//   receive_ready     out  registered ready (1 from first cycle after reset)
//   receive_flit      in   inbound flit
//   receive_is_header in   inbound flit is a header
//   receive_is_tail   in   inbound flit is a tail
//   receive_num       out  complete packets received (saturating)
//   check_err_num     out  field errors seen (only with the macro defined)
// ---------------------------------------------------------------------------
module noc_test_node_rx
  import noc_pkg::*;
#(
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0,
  parameter int DATA_WIDTH = noc_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  receive_valid,
  output logic                  receive_ready,
  input  logic [DATA_WIDTH-1:0] receive_flit,
  input  logic                  receive_is_header,
  input  logic                  receive_is_tail,
  output logic [7:0]            receive_num
`ifdef NOC_TEST_NODE_CHECK_EN
  ,
  output logic [7:0]            check_err_num
`endif
);

  logic       ready_reg;
  logic       in_pkt_reg;
  logic [7:0] num_reg;
  logic       accept;
  logic       pkt_done;
  logic       pkt_ok;

  // Only the low fields carry information; fold the whole flit so every bit
  // is consumed regardless of build options.
  logic unused_flit;
  assign unused_flit = ^receive_flit;

  assign accept   = receive_valid && ready_reg;
  // A single-flit packet (header and tail together) completes on its own.
  assign pkt_done = accept && receive_is_tail && (in_pkt_reg || receive_is_header);

`ifdef NOC_TEST_NODE_CHECK_EN
  localparam logic [COORD_W-1:0] OWN_X = COORD_W'(X_ID);
  localparam logic [COORD_W-1:0] OWN_Y = COORD_W'(Y_ID);

  logic [SEQ_W-1:0] exp_seq_reg;
  logic [IDX_W-1:0] exp_idx_reg;
  logic             pkt_err_reg;
  logic [7:0]       err_reg;
  logic             hdr_bad;
  logic             body_bad;
  logic             flit_err;

  assign hdr_bad  = (receive_flit[HDR_DX_LSB +: COORD_W] != OWN_X) ||
                    (receive_flit[HDR_DY_LSB +: COORD_W] != OWN_Y);
  assign body_bad = (receive_flit[PAY_IDX_LSB +: IDX_W] != exp_idx_reg) ||
                    (receive_flit[PAY_SEQ_LSB +: SEQ_W] != exp_seq_reg);
  // Orphan body/tail flits (no open packet) are ignored, not flagged.
  assign flit_err = accept && (receive_is_header ? hdr_bad : (in_pkt_reg && body_bad));
  assign pkt_ok   = receive_is_header ? !hdr_bad : (!pkt_err_reg && !body_bad);

  always_ff @(posedge clk) begin
    if (srst) begin
      exp_seq_reg <= '0;
      exp_idx_reg <= '0;
      pkt_err_reg <= 1'b0;
      err_reg     <= '0;
    end else begin
      if (accept && receive_is_header) begin
        exp_seq_reg <= receive_flit[HDR_SEQ_LSB +: SEQ_W];
        exp_idx_reg <= IDX_W'(1);
        pkt_err_reg <= hdr_bad;
      end else if (accept && in_pkt_reg) begin
        exp_idx_reg <= exp_idx_reg + IDX_W'(1);
        pkt_err_reg <= pkt_err_reg || body_bad;
      end
      if (flit_err && (err_reg != 8'hFF)) begin
        err_reg <= err_reg + 8'd1;
      end
    end
  end

  assign check_err_num = err_reg;
`else
  assign pkt_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      ready_reg  <= 1'b0;
      in_pkt_reg <= 1'b0;
      num_reg    <= '0;
    end else begin
      ready_reg <= 1'b1;
      if (accept) begin
        if (receive_is_header) begin
          // A header while in a packet silently restarts framing.
          in_pkt_reg <= !receive_is_tail;
        end else if (receive_is_tail) begin
          in_pkt_reg <= 1'b0;
        end
      end
      if (pkt_done && pkt_ok && (num_reg != 8'hFF)) begin
        num_reg <= num_reg + 8'd1;
      end
    end
  end

  assign receive_ready = ready_reg;
  assign receive_num   = num_reg;

endmodule

// File: rtl/noc_test_node.sv
// ---------------------------------------------------------------------------
// noc_test_node
// Traffic endpoint for one NoC router local port. After reset it waits
// START_DLY cycles, then sends NUM_PKTS packets of PKT_LEN flits to
// (DEST_X_ID, DEST_Y_ID) with GAP idle cycles between packets; it also counts
// packets delivered to it (see noc_test_node_rx).
//
// Optional feature macro: NOC_TEST_NODE_CHECK_EN (adds check_err_num output).
//
// Ports
//   noc_clk            in   clock
//   noc_rst_n          in   synchronous reset, active HIGH despite the name
//   receive_valid      in   inbound flit valid
//   receive_ready      out  node accepts inbound flit
//   receive_flit       in   inbound flit
//   receive_is_header  in   inbound header flag
//   receive_is_tail    in   inbound tail flag
//   sender_valid       out  outbound flit valid
//   sender_ready       in   router accepts outbound flit
//   sender_flit        out  outbound flit
//   sender_is_header   out  outbound header flag
//   sender_is_tail     out  outbound tail flag
//   receive_num        out  complete packets received (saturating at 255)
//   check_err_num      out  checker error count (macro builds only)
// ---------------------------------------------------------------------------
module noc_test_node
  import noc_pkg::*;
#(
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0,
  parameter int DEST_X_ID  = 1,
  parameter int DEST_Y_ID  = 1,
  parameter int DATA_WIDTH = noc_pkg::DATA_WIDTH,
  parameter int PKT_LEN    = 4,
  parameter int NUM_PKTS   = 8,
  parameter int START_DLY  = 4,
  parameter int GAP        = 2
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic                  receive_valid,
  output logic                  receive_ready,
  input  logic [DATA_WIDTH-1:0] receive_flit,
  input  logic                  receive_is_header,
  input  logic                  receive_is_tail,
  output logic                  sender_valid,
  input  logic                  sender_ready,
  output logic [DATA_WIDTH-1:0] sender_flit,
  output logic                  sender_is_header,
  output logic                  sender_is_tail,
  output logic [7:0]            receive_num
`ifdef NOC_TEST_NODE_CHECK_EN
  ,
  output logic [7:0]            check_err_num
`endif
);

  localparam logic [COORD_W-1:0] OWN_X  = COORD_W'(X_ID);
  localparam logic [COORD_W-1:0] OWN_Y  = COORD_W'(Y_ID);
  localparam logic [COORD_W-1:0] DST_X  = COORD_W'(DEST_X_ID);
  localparam logic [COORD_W-1:0] DST_Y  = COORD_W'(DEST_Y_ID);
  localparam logic [15:0]        DLY_LAST  = 16'(START_DLY - 1);
  localparam logic [15:0]        GAP_LAST  = 16'(GAP - 1);
  localparam logic [IDX_W-1:0]   BODY_LAST = IDX_W'(PKT_LEN - 2);
  localparam logic [7:0]         PKT_LAST  = 8'(NUM_PKTS - 1);
  // With no start delay the first header is presented straight out of reset.
  localparam tx_state_t RST_STATE = (START_DLY == 0) ? TX_HEAD : TX_WAIT;

  tx_state_t        state_reg, state_next;
  logic [15:0]      dly_reg,   dly_next;   // WAIT / GAP cycle counter
  logic [IDX_W-1:0] idx_reg,   idx_next;   // flit index within the packet
  logic [SEQ_W-1:0] seq_reg,   seq_next;   // packet sequence number
  logic [7:0]       pkt_reg,   pkt_next;   // packets completed so far

  always_ff @(posedge noc_clk) begin
    if (noc_rst_n) begin
      state_reg <= RST_STATE;
      dly_reg   <= '0;
      idx_reg   <= '0;
      seq_reg   <= '0;
      pkt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      dly_reg   <= dly_next;
      idx_reg   <= idx_next;
      seq_reg   <= seq_next;
      pkt_reg   <= pkt_next;
    end
  end

  // Outputs are decoded from registered state only, so flit and flags hold
  // steady for as long as the router back-pressures.
  always_comb begin
    state_next       = state_reg;
    dly_next         = dly_reg;
    idx_next         = idx_reg;
    seq_next         = seq_reg;
    pkt_next         = pkt_reg;
    sender_valid     = 1'b0;
    sender_is_header = 1'b0;
    sender_is_tail   = 1'b0;
    sender_flit      = '0;

    case (state_reg)
      TX_WAIT: begin
        if (dly_reg == DLY_LAST) begin
          state_next = TX_HEAD;
          dly_next   = '0;
        end else begin
          dly_next = dly_reg + 16'd1;
        end
      end

      TX_HEAD: begin
        sender_valid                = 1'b1;
        sender_is_header            = 1'b1;
        sender_flit[FIELDS_W-1:0]   = make_header(DST_X, DST_Y, OWN_X, OWN_Y, seq_reg);
        if (sender_ready) begin
          idx_next   = IDX_W'(1);
          state_next = (PKT_LEN == 2) ? TX_TAIL : TX_BODY;
        end
      end

      TX_BODY: begin
        sender_valid              = 1'b1;
        sender_flit[FIELDS_W-1:0] = make_payload(OWN_X, OWN_Y, seq_reg, idx_reg);
        if (sender_ready) begin
          idx_next = idx_reg + IDX_W'(1);
          if (idx_reg == BODY_LAST) begin
            state_next = TX_TAIL;
          end
        end
      end

      TX_TAIL: begin
        sender_valid              = 1'b1;
        sender_is_tail            = 1'b1;
        sender_flit[FIELDS_W-1:0] = make_payload(OWN_X, OWN_Y, seq_reg, idx_reg);
        if (sender_ready) begin
          seq_next = seq_reg + SEQ_W'(1);
          idx_next = '0;
          if (pkt_reg == PKT_LAST) begin
            state_next = TX_DONE;
          end else begin
            pkt_next = pkt_reg + 8'd1;
            dly_next = '0;
            state_next = (GAP == 0) ? TX_HEAD : TX_GAP;
          end
        end
      end

      TX_GAP: begin
        if (dly_reg == GAP_LAST) begin
          state_next = TX_HEAD;
          dly_next   = '0;
        end else begin
          dly_next = dly_reg + 16'd1;
        end
      end

      TX_DONE: begin
        state_next = TX_DONE;
      end

      default: begin
        state_next = RST_STATE;
      end
    endcase
  end

  noc_test_node_rx #(
    .X_ID       (X_ID),
    .Y_ID       (Y_ID),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rx (
    .clk               (noc_clk),
    .srst              (noc_rst_n),
    .receive_valid     (receive_valid),
    .receive_ready     (receive_ready),
    .receive_flit      (receive_flit),
    .receive_is_header (receive_is_header),
    .receive_is_tail   (receive_is_tail),
    .receive_num       (receive_num)
`ifdef NOC_TEST_NODE_CHECK_EN
    ,
    .check_err_num     (check_err_num)
`endif
  );

endmodule

// File: tb/tb_noc_test_node.sv
// ---------------------------------------------------------------------------
// tb_noc_test_node
// Directed bench. u_dut runs in loopback (sender_* feeding receive_*) with
// DEST = own ID, GAP = 0, then switches to injected receive traffic.
// u_gap sends two 2-flit packets with GAP = 2 into an always-ready router.
// ---------------------------------------------------------------------------
module tb_noc_test_node;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        loop_en;
  logic        tb_ready;
  logic        inj_valid;
  logic        inj_hdr;
  logic        inj_tail;
  logic [31:0] inj_flit;

  logic        s_valid, s_ready, s_hdr, s_tail;
  logic [31:0] s_flit;
  logic        r_valid, r_ready, r_hdr, r_tail;
  logic [31:0] r_flit;
  logic [7:0]  r_num;

  logic        g_valid, g_hdr, g_tail, g_rready;
  logic [31:0] g_flit;
  logic [7:0]  g_num;

`ifdef NOC_TEST_NODE_CHECK_EN
  logic [7:0]  r_err;
  logic [7:0]  g_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Loopback: receiver sees a flit only when the sender handshake happens.
  assign s_ready = loop_en ? (tb_ready & r_ready) : tb_ready;
  assign r_valid = loop_en ? (s_valid & tb_ready) : inj_valid;
  assign r_flit  = loop_en ? s_flit : inj_flit;
  assign r_hdr   = loop_en ? s_hdr  : inj_hdr;
  assign r_tail  = loop_en ? s_tail : inj_tail;

  noc_test_node #(
    .X_ID(0), .Y_ID(0), .DEST_X_ID(0), .DEST_Y_ID(0), .DATA_WIDTH(32),
    .PKT_LEN(4), .NUM_PKTS(8), .START_DLY(4), .GAP(0)
  ) u_dut (
    .noc_clk           (clk),
    .noc_rst_n         (rst),
    .receive_valid     (r_valid),
    .receive_ready     (r_ready),
    .receive_flit      (r_flit),
    .receive_is_header (r_hdr),
    .receive_is_tail   (r_tail),
    .sender_valid      (s_valid),
    .sender_ready      (s_ready),
    .sender_flit       (s_flit),
    .sender_is_header  (s_hdr),
    .sender_is_tail    (s_tail),
    .receive_num       (r_num)
`ifdef NOC_TEST_NODE_CHECK_EN
    ,
    .check_err_num     (r_err)
`endif
  );

  noc_test_node #(
    .X_ID(0), .Y_ID(0), .DEST_X_ID(1), .DEST_Y_ID(1), .DATA_WIDTH(32),
    .PKT_LEN(2), .NUM_PKTS(2), .START_DLY(2), .GAP(2)
  ) u_gap (
    .noc_clk           (clk),
    .noc_rst_n         (rst),
    .receive_valid     (1'b0),
    .receive_ready     (g_rready),
    .receive_flit      (32'h0),
    .receive_is_header (1'b0),
    .receive_is_tail   (1'b0),
    .sender_valid      (g_valid),
    .sender_ready      (1'b1),
    .sender_flit       (g_flit),
    .sender_is_header  (g_hdr),
    .sender_is_tail    (g_tail),
    .receive_num       (g_num)
`ifdef NOC_TEST_NODE_CHECK_EN
    ,
    .check_err_num     (g_err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Present one flit for one cycle; the receiver is ready, so it is taken.
  task automatic inject(input logic [31:0] f, input logic h, input logic t);
    inj_flit  = f;
    inj_hdr   = h;
    inj_tail  = t;
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    inj_hdr   = 1'b0;
    inj_tail  = 1'b0;
    inj_flit  = 32'h0;
  endtask

  initial begin
    logic [63:0] exp_v;
    int          hs;
    int          p;
    int          fi;

    rst       = 1'b1;
    loop_en   = 1'b1;
    tb_ready  = 1'b0;
    inj_valid = 1'b0;
    inj_hdr   = 1'b0;
    inj_tail  = 1'b0;
    inj_flit  = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_s_valid", 64'(s_valid), 64'd0);
    chk("rst_s_flit",  64'({s_hdr, s_tail, s_flit}), 64'd0);
    chk("rst_r_ready", 64'(r_ready), 64'd0);
    chk("rst_r_num",   64'(r_num),   64'd0);
`ifdef NOC_TEST_NODE_CHECK_EN
    chk("rst_err",     64'(r_err),   64'd0);
`endif
    rst = 1'b0;

    // Cycles 1..24 after release: header appears at cycle 4 and is held
    // under back-pressure; u_gap follows its own fixed schedule.
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("r_ready_after_rst", 64'(r_ready), 64'd1);
      end
      exp_v = (c < 4) ? 64'd0 : {29'd0, 3'b110, 32'h0000_0000};
      chk($sformatf("tx_hold_c%0d", c), {29'd0, s_valid, s_hdr, s_tail, s_flit}, exp_v);
      if (c <= 10) begin
        case (c)
          2:       exp_v = {29'd0, 3'b110, 32'h0000_0011};
          3:       exp_v = {29'd0, 3'b101, 32'h0000_0001};
          6:       exp_v = {29'd0, 3'b110, 32'h0001_0011};
          7:       exp_v = {29'd0, 3'b101, 32'h0000_0101};
          default: exp_v = 64'd0;
        endcase
        chk($sformatf("gap_c%0d", c), {29'd0, g_valid, g_hdr, g_tail, g_flit}, exp_v);
      end
    end

    // Release back-pressure: 32 consecutive handshakes expected.
    tb_ready = 1'b1;
    #1;
    hs = 0;
    for (int cyc = 0; cyc < 200 && hs < 32; cyc++) begin
      if (s_valid && s_ready) begin
        p  = hs / 4;
        fi = hs % 4;
        exp_v = {30'd0, (fi == 0), (fi == 3),
                 (fi == 0) ? 32'(p << 16) : 32'((p << 8) | fi)};
        chk($sformatf("tx_flit_%0d", hs), {30'd0, s_hdr, s_tail, s_flit}, exp_v);
        chk($sformatf("tx_contig_%0d", hs), 64'(cyc), 64'(hs));
        hs++;
      end
      @(negedge clk);
    end
    chk("tx_handshakes", 64'(hs), 64'd32);
    repeat (3) @(negedge clk);
    chk("tx_done_valid", 64'(s_valid), 64'd0);
    chk("loop_r_num",    64'(r_num),   64'd8);
`ifdef NOC_TEST_NODE_CHECK_EN
    chk("loop_err",      64'(r_err),   64'd0);
`endif

    // Injected receive traffic.
    loop_en  = 1'b0;
    tb_ready = 1'b0;
    inject(32'h0000_0703, 1'b0, 1'b1);
    chk("rx_orphan_tail", 64'(r_num), 64'd8);
    inject(32'h0005_0000, 1'b1, 1'b0);
    inject(32'h0006_0000, 1'b1, 1'b0);
    chk("rx_two_headers", 64'(r_num), 64'd8);
    inject(32'h0000_0601, 1'b0, 1'b0);
    chk("rx_body", 64'(r_num), 64'd8);
    inject(32'h0000_0602, 1'b0, 1'b1);
    chk("rx_restart_tail", 64'(r_num), 64'd9);
`ifdef NOC_TEST_NODE_CHECK_EN
    chk("rx_err_clean", 64'(r_err), 64'd0);
    inject(32'h0000_0011, 1'b1, 1'b1);
    chk("chk_bad_dest_err", 64'(r_err), 64'd1);
    chk("chk_bad_dest_num", 64'(r_num), 64'd9);
`endif

    // Reset in the middle of a received packet.
    inject(32'h0009_0000, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_r_ready", 64'(r_ready), 64'd0);
    chk("mid_rst_r_num",   64'(r_num),   64'd0);
    chk("mid_rst_s_valid", 64'(s_valid), 64'd0);
    chk("mid_rst_s_flit",  64'({s_hdr, s_tail, s_flit}), 64'd0);
`ifdef NOC_TEST_NODE_CHECK_EN
    chk("mid_rst_err",     64'(r_err),   64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(r_ready), 64'd1);
    inject(32'h0000_0902, 1'b0, 1'b1);
    chk("rx_abandoned_pkt", 64'(r_num), 64'd0);

    // Saturation with single-flit packets.
    for (int i = 0; i < 300; i++) begin
      inject(32'h0000_0000, 1'b1, 1'b1);
      if (i == 253) begin
        chk("rx_num_254", 64'(r_num), 64'd254);
      end
    end
    chk("rx_num_sat", 64'(r_num), 64'd255);
    chk("gap_rx_idle", 64'({g_rready, g_num}), 64'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
